// File: rtl/inv_key_schedule.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inv_key_schedule: AES-128 round keys generated backward, round 10 to 0.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module inv_key_schedule (
   input  logic         clock,
   input  logic         reset,
   input  logic         inicio,
   input  logic [127:0] chaveFinal,
   input  logic         proxima,
   output logic [127:0] chaveRodada,
   output logic [3:0]   rodada,
   output logic         valido,
   output logic         pronto
);

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] c_sbox = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   typedef enum logic [0:0] {OCIOSO = 1'b0, ATIVO = 1'b1} state_t;

   state_t         r_state;
   logic [127:0]   r_key;
   logic [3:0]     r_rodada;
   logic           r_valido;
   logic           r_pronto;

   logic [31:0]    w_w0, w_w1, w_w2, w_w3;
   logic [31:0]    w_w0n, w_w1n, w_w2n, w_w3n;
   logic [31:0]    w_rot, w_sub;
   logic [7:0]     w_rcon;

   assign w_w0 = r_key[127:96];
   assign w_w1 = r_key[95:64];
   assign w_w2 = r_key[63:32];
   assign w_w3 = r_key[31:0];

   assign w_w3n = w_w3 ^ w_w2;
   assign w_w2n = w_w2 ^ w_w1;
   assign w_w1n = w_w1 ^ w_w0;
   assign w_rot = {w_w3n[23:0], w_w3n[31:24]};

   // {~x, 3'b000} is the bit offset of entry x counted from the LSB end.
   generate
      for (genvar g = 0; g < 4; g++) begin : g_sbox
         assign w_sub[8*g +: 8] = c_sbox[{~w_rot[8*g +: 8], 3'b000} +: 8];
      end
   endgenerate

   always_comb begin
      w_rcon = 8'h00;
      case (r_rodada)
         4'd1:    w_rcon = 8'h01;
         4'd2:    w_rcon = 8'h02;
         4'd3:    w_rcon = 8'h04;
         4'd4:    w_rcon = 8'h08;
         4'd5:    w_rcon = 8'h10;
         4'd6:    w_rcon = 8'h20;
         4'd7:    w_rcon = 8'h40;
         4'd8:    w_rcon = 8'h80;
         4'd9:    w_rcon = 8'h1b;
         4'd10:   w_rcon = 8'h36;
         default: w_rcon = 8'h00;
      endcase
   end

   assign w_w0n = w_w0 ^ w_sub ^ {w_rcon, 24'h000000};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= OCIOSO;
         r_key    <= '0;
         r_rodada <= 4'd0;
         r_valido <= 1'b0;
         r_pronto <= 1'b0;
      end else begin
         r_pronto <= 1'b0;
         case (r_state)
            OCIOSO: begin
               if (inicio) begin
                  r_state  <= ATIVO;
                  r_key    <= chaveFinal;
                  r_rodada <= 4'd10;
                  r_valido <= 1'b1;
               end
            end
            ATIVO: begin
               if (inicio) begin
                  r_key    <= chaveFinal;
                  r_rodada <= 4'd10;
               end else if (proxima) begin
                  if (r_rodada != 4'd0) begin
                     r_key    <= {w_w0n, w_w1n, w_w2n, w_w3n};
                     r_rodada <= r_rodada - 4'd1;
                  end else begin
                     // Round 0 consumed: keep the cipher key visible.
                     r_state  <= OCIOSO;
                     r_valido <= 1'b0;
                     r_pronto <= 1'b1;
                  end
               end
            end
            default: begin
               r_state  <= OCIOSO;
               r_valido <= 1'b0;
            end
         endcase
      end
   end

   assign chaveRodada = r_key;
   assign rodada      = r_rodada;
   assign valido      = r_valido;
   assign pronto      = r_pronto;

endmodule
`default_nettype wire

// File: tb/tb_inv_key_schedule.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inv_key_schedule: directed bench with an expected-output queue.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_inv_key_schedule;

   logic         clock;
   logic         reset;
   logic         inicio;
   logic [127:0] chaveFinal;
   logic         proxima;
   logic [127:0] chaveRodada;
   logic [3:0]   rodada;
   logic         valido;
   logic         pronto;

   inv_key_schedule dut (
      .clock       (clock),
      .reset       (reset),
      .inicio      (inicio),
      .chaveFinal  (chaveFinal),
      .proxima     (proxima),
      .chaveRodada (chaveRodada),
      .rodada      (rodada),
      .valido      (valido),
      .pronto      (pronto)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [127:0] key;
      logic [3:0]   rnd;
      logic         vld;
      logic         prt;
   } exp_t;

   exp_t         sb[$];
   logic [127:0] tbl [0:10];
   int           total = 0;
   int           bad   = 0;
   int           stepn = 0;

   // Reference model state
   logic         m_act;
   logic [127:0] m_key;
   logic [3:0]   m_rnd;
   logic         m_prt;

   task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s step=%0d observed=%h expected=%h", nm, stepn, obs, exp);
      end
   endtask

   task automatic cyc(input logic ini, input logic prx, input logic rst, input logic [127:0] k);
      exp_t e;
      reset      = rst;
      inicio     = ini;
      proxima    = prx;
      chaveFinal = ini ? k : {$urandom, $urandom, $urandom, $urandom};
      m_prt = 1'b0;
      if (rst) begin
         m_act = 1'b0; m_key = '0; m_rnd = 4'd0;
      end else if (ini) begin
         m_act = 1'b1; m_key = k; m_rnd = 4'd10;
      end else if (m_act && prx) begin
         if (m_rnd != 4'd0) begin
            m_rnd = m_rnd - 4'd1;
            m_key = tbl[m_rnd];
         end else begin
            m_act = 1'b0;
            m_prt = 1'b1;
         end
      end
      e.key = m_key; e.rnd = m_rnd; e.vld = m_act; e.prt = m_prt;
      sb.push_back(e);
      @(posedge clock);
      #1;
      stepn++;
      e = sb.pop_front();
      chk("chaveRodada", chaveRodada, e.key);
      chk("rodada", {124'd0, rodada}, {124'd0, e.rnd});
      chk("valido", {127'd0, valido}, {127'd0, e.vld});
      chk("pronto", {127'd0, pronto}, {127'd0, e.prt});
   endtask

   initial begin
      tbl[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      tbl[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      tbl[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      tbl[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      tbl[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      tbl[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      tbl[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      tbl[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      tbl[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      tbl[9]  = 128'hac7766f319fadc2128d12941575c006e;
      tbl[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      m_act = 1'b0; m_key = '0; m_rnd = 4'd0; m_prt = 1'b0;
      reset = 1'b1; inicio = 1'b0; proxima = 1'b0; chaveFinal = '0;

      // Reset values
      cyc(0, 0, 1, '0);
      cyc(0, 0, 1, '0);
      // Idle: proxima before any inicio
      cyc(0, 1, 0, '0);
      cyc(0, 1, 0, '0);
      cyc(0, 0, 0, '0);

      // Load, single step, then continuous proxima through pronto
      cyc(1, 0, 0, tbl[10]);
      cyc(0, 1, 0, '0);
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, '0);
      cyc(0, 1, 0, '0);
      cyc(0, 0, 0, '0);
      cyc(0, 1, 0, '0);
      cyc(0, 1, 0, '0);

      // Stall: pseudo-random proxima, then drain to pronto
      cyc(1, 0, 0, tbl[10]);
      for (int i = 0; i < 30; i++) cyc(0, 1'($urandom_range(0, 1)), 0, '0);
      for (int i = 0; i < 13; i++) cyc(0, 1, 0, '0);

      // Restart at round 4 with inicio and proxima together
      cyc(1, 0, 0, tbl[10]);
      for (int i = 0; i < 6; i++) cyc(0, 1, 0, '0);
      cyc(1, 1, 0, 128'h00112233445566778899aabbccddeeff);
      cyc(0, 0, 0, '0);

      // Reset at round 6 together with inicio
      cyc(1, 0, 0, tbl[10]);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, '0);
      cyc(1, 1, 1, tbl[10]);
      cyc(0, 1, 0, '0);
      cyc(0, 1, 0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
